// File: rtl/cache_assoc.sv
// cache_assoc: N-way set-associative, write-back, write-allocate cache.
// A CPU word port sits in front of a 128-bit burst memory port. Each line
// holds 16 words, which travel to and from memory as 4 beats.
// Victim choice: the lowest-index invalid way; if every way is valid, the
// per-set round-robin pointer. Misses are filled and then replayed through
// LOOKUP, so a store always merges into a resident line.
module cache_assoc #(
  parameter int SETS           = 64,
  parameter int WAYS           = 2,
  parameter int CPU_WIDTH      = 32,
  parameter int WORD_ADDR_BITS = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  // CPU side
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic [WORD_ADDR_BITS-1:0] cpu_req_addr,
  input  logic [CPU_WIDTH-1:0]      cpu_req_data,
  input  logic [3:0]                cpu_req_write,
  output logic                      cpu_resp_valid,
  output logic [CPU_WIDTH-1:0]      cpu_resp_data,
  // Memory side
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [WORD_ADDR_BITS-3:0] mem_req_addr,
  output logic                      mem_req_rw,
  output logic                      mem_req_data_valid,
  input  logic                      mem_req_data_ready,
  output logic [127:0]              mem_req_data_bits,
  output logic [15:0]               mem_req_data_mask,
  input  logic                      mem_resp_valid,
  input  logic [127:0]              mem_resp_data
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_BITS = WORD_ADDR_BITS - 4 - IDX_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_WB_DATA,
    S_FILL_REQ,
    S_FILL_DATA
  } state_t;

  // Control state and the latched request
  state_t                      state_q;
  logic [1:0]                  beat_q;
  logic [WORD_ADDR_BITS-1:0]   addr_q;
  logic [CPU_WIDTH-1:0]        wdata_q;
  logic [3:0]                  wmask_q;
  logic [WAY_BITS-1:0]         victim_q;
  logic                        victim_by_ptr_q;
  logic                        resp_valid_q;
  logic [CPU_WIDTH-1:0]        resp_data_q;

  // Per-way line state
  logic                        valid_q [SETS][WAYS];
  logic                        dirty_q [SETS][WAYS];
  logic [TAG_BITS-1:0]         tag_q   [SETS][WAYS];
  logic [WAY_BITS-1:0]         rr_q    [SETS];

  // Line data, one entry per beat
  logic [127:0]                data_q  [SETS][WAYS][4];

  // Fields of the latched request address
  logic [TAG_BITS-1:0]         req_tag;
  logic [IDX_BITS-1:0]         req_idx;
  logic [1:0]                  req_beat;
  logic [1:0]                  req_off;

  assign req_tag  = addr_q[WORD_ADDR_BITS-1 -: TAG_BITS];
  assign req_idx  = addr_q[4 +: IDX_BITS];
  assign req_beat = addr_q[3:2];
  assign req_off  = addr_q[1:0];

  // Hit detection and victim selection for the latched request
  logic                        hit;
  logic [WAY_BITS-1:0]         hit_way;
  logic                        have_invalid;
  logic [WAY_BITS-1:0]         invalid_way;
  logic [WAY_BITS-1:0]         miss_victim;
  logic                        victim_dirty;

  // Tag compare across all ways and lowest-index invalid way search
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the block leaves one unassigned and a latch is never inferred.
    hit          = 1'b0;
    hit_way      = '0;
    have_invalid = 1'b0;
    invalid_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
    // Scanning downwards leaves the lowest invalid index as the final winner
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        have_invalid = 1'b1;
        invalid_way  = WAY_BITS'(w);
      end
    end
    miss_victim  = have_invalid ? invalid_way : rr_q[req_idx];
    victim_dirty = valid_q[req_idx][miss_victim] && dirty_q[req_idx][miss_victim];
  end

  // Word read from the hit line, and the same beat with the store bytes merged in
  logic [127:0]                hit_beat;
  logic [CPU_WIDTH-1:0]        hit_word;
  logic [127:0]                merged_beat;

  // Byte-masked merge of the latched store data into the hit beat
  always_comb begin
    hit_beat    = data_q[req_idx][hit_way][req_beat];
    hit_word    = hit_beat[CPU_WIDTH*int'(req_off) +: CPU_WIDTH];
    merged_beat = hit_beat;
    for (int b = 0; b < 4; b++) begin
      if (wmask_q[b]) begin
        merged_beat[CPU_WIDTH*int'(req_off) + 8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  // Single write port into the data array: a store hit or a fill beat
  logic                        data_we_d;
  logic [WAY_BITS-1:0]         data_way_d;
  logic [1:0]                  data_beat_d;
  logic [127:0]                data_wdata_d;

  // Data array write-port selection
  always_comb begin
    data_we_d    = 1'b0;
    data_way_d   = hit_way;
    data_beat_d  = req_beat;
    data_wdata_d = merged_beat;
    if (state_q == S_LOOKUP && hit && wmask_q != 4'b0000) begin
      data_we_d = 1'b1;
    end else if (state_q == S_FILL_DATA && mem_resp_valid) begin
      data_we_d    = 1'b1;
      data_way_d   = victim_q;
      data_beat_d  = beat_q;
      data_wdata_d = mem_resp_data;
    end
  end

  // Data array storage
  // NOTE: the data array has no reset. Valid bits gate every use of it, and leaving it out of reset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (data_we_d) begin
      data_q[req_idx][data_way_d][data_beat_d] <= data_wdata_d;
    end
  end

  // Main controller: request latch, line state, replacement pointer and response
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      beat_q          <= 2'd0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wmask_q         <= 4'b0000;
      victim_q        <= '0;
      victim_by_ptr_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
        end
      end
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req_valid) begin
            addr_q  <= cpu_req_addr;
            wdata_q <= cpu_req_data;
            wmask_q <= cpu_req_write;
            state_q <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (hit) begin
            if (wmask_q == 4'b0000) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= hit_word;
            end else begin
              dirty_q[req_idx][hit_way] <= 1'b1;
            end
            state_q <= S_IDLE;
          end else begin
            victim_q        <= miss_victim;
            victim_by_ptr_q <= !have_invalid;
            beat_q          <= 2'd0;
            state_q         <= victim_dirty ? S_WB_REQ : S_FILL_REQ;
          end
        end

        S_WB_REQ: begin
          if (mem_req_ready) begin
            state_q <= S_WB_DATA;
          end
        end

        S_WB_DATA: begin
          if (mem_req_data_ready) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              state_q <= S_FILL_REQ;
            end
          end
        end

        S_FILL_REQ: begin
          if (mem_req_ready) begin
            state_q <= S_FILL_DATA;
          end
        end

        S_FILL_DATA: begin
          if (mem_resp_valid) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              tag_q[req_idx][victim_q]   <= req_tag;
              valid_q[req_idx][victim_q] <= 1'b1;
              dirty_q[req_idx][victim_q] <= 1'b0;
              if (victim_by_ptr_q) begin
                rr_q[req_idx] <= (WAYS == 1) ? '0 : rr_q[req_idx] + WAY_BITS'(1);
              end
              state_q <= S_LOOKUP;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decodes of the controller state
  logic [TAG_BITS-1:0] victim_tag;
  assign victim_tag = tag_q[req_idx][victim_q];

  // Memory command address: the victim line for write-back, the requested line for fill
  always_comb begin
    mem_req_addr = '0;
    case (state_q)
      S_WB_REQ:   mem_req_addr = {victim_tag, req_idx, 2'b00};
      S_FILL_REQ: mem_req_addr = {req_tag, req_idx, 2'b00};
      default:    mem_req_addr = '0;
    endcase
  end

  assign cpu_req_ready      = (state_q == S_IDLE) && !reset;
  assign mem_req_valid      = (state_q == S_WB_REQ) || (state_q == S_FILL_REQ);
  assign mem_req_rw         = (state_q == S_WB_REQ);
  assign mem_req_data_valid = (state_q == S_WB_DATA);
  assign mem_req_data_bits  = (state_q == S_WB_DATA) ? data_q[req_idx][victim_q][beat_q] : '0;
  assign mem_req_data_mask  = 16'hFFFF;
  assign cpu_resp_valid     = resp_valid_q;
  assign cpu_resp_data      = resp_data_q;

endmodule

// File: tb/tb_cache_assoc.sv
// tb_cache_assoc: randomized scoreboard bench for cache_assoc.
// The reference treats memory as a flat word array (CPU view), next to a
// directory of resident lines kept by the replacement rules. A behavioural
// memory answers the DUT's commands and checks write-back data.
module tb_cache_assoc;

  localparam int SETS     = 64;
  localparam int WAYS     = 2;
  localparam int IDX_BITS = 6;
  localparam int TIMEOUT  = 5000;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic [29:0]  cpu_req_addr;
  logic [31:0]  cpu_req_data;
  logic [3:0]   cpu_req_write;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_data;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr;
  logic         mem_req_rw;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  cache_assoc #(.SETS(SETS), .WAYS(WAYS), .CPU_WIDTH(32), .WORD_ADDR_BITS(30)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data), .cpu_req_write(cpu_req_write),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] data; int acc; bit hit; } exp_t;
  typedef struct { bit rw; logic [27:0] addr; } cmd_t;
  typedef struct { bit v; bit d; int unsigned tag; } mline_t;

  exp_t        exp_q[$];
  cmd_t        cmd_q[$];
  mline_t      mdir [SETS][WAYS];
  int unsigned mrr  [SETS];
  bit [31:0]   ref_mem [int unsigned];   // CPU-visible contents
  bit [31:0]   bk_mem  [int unsigned];   // backing memory contents

  function automatic logic [31:0] init_word(input int unsigned a);
    return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1357};
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bk_rd(input int unsigned a);
    return bk_mem.exists(a) ? bk_mem[a] : init_word(a);
  endfunction

  function automatic void preload(input int unsigned a, input logic [31:0] v);
    ref_mem[a] = v;
    bk_mem[a]  = v;
  endfunction

  // Applies one access to the line directory; queues the expected memory commands
  function automatic bit model_access(input logic [29:0] a, input bit is_wr);
    int unsigned ua;
    int unsigned idx;
    int unsigned tag;
    int          vw;
    bit          by_ptr;
    cmd_t        c;
    ua  = a;
    idx = (ua / 16) % SETS;
    tag = ua / (16 * SETS);
    vw  = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (mdir[idx][w].v && mdir[idx][w].tag == tag) begin
        if (is_wr) mdir[idx][w].d = 1'b1;
        return 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (vw < 0 && !mdir[idx][w].v) vw = w;
    end
    by_ptr = (vw < 0);
    if (by_ptr) vw = int'(mrr[idx]);
    if (mdir[idx][vw].v && mdir[idx][vw].d) begin
      c.rw   = 1'b1;
      c.addr = 28'((mdir[idx][vw].tag * SETS + idx) * 4);
      cmd_q.push_back(c);
    end
    c.rw   = 1'b0;
    c.addr = 28'((tag * SETS + idx) * 4);
    cmd_q.push_back(c);
    mdir[idx][vw].v   = 1'b1;
    mdir[idx][vw].d   = is_wr;
    mdir[idx][vw].tag = tag;
    if (by_ptr) mrr[idx] = (mrr[idx] + 1) % WAYS;
    return 1'b0;
  endfunction

  // Reset empties the cache: anything not yet written back is lost
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mdir[s][w].v   = 1'b0;
        mdir[s][w].d   = 1'b0;
        mdir[s][w].tag = 0;
      end
    end
    ref_mem.delete();
    foreach (bk_mem[k]) ref_mem[k] = bk_mem[k];
    exp_q.delete();
    cmd_q.delete();
  endtask

  // ---------------- behavioural memory + protocol checks ----------------
  int          rstate = 0;       // 0 idle, 1 write-back beats, 2 fill beats
  int          rbeat  = 0;
  int          stall_cnt = 0;
  int          dstall_cnt = 0;
  bit          cmd_pend = 1'b0;
  int          force_cmd_stall = 0;
  int          force_data_stall = 0;
  int          last_fill_cyc = 0;
  logic [27:0] r_addr = '0;
  bit          p_cmd_wait = 1'b0;
  logic [27:0] p_addr = '0;
  logic        p_rw = 1'b0;
  bit          p_dat_wait = 1'b0;
  logic [127:0] p_bits = '0;

  always @(negedge clk) begin
    if (reset) begin
      rstate = 0; rbeat = 0; stall_cnt = 0; dstall_cnt = 0; cmd_pend = 1'b0;
      p_cmd_wait = 1'b0; p_dat_wait = 1'b0;
      mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_data = '0;
    end else begin
      if (p_cmd_wait) begin
        check("cmd_valid_hold", mem_req_valid, 1'b1);
        check("cmd_addr_hold", mem_req_addr, p_addr);
        check("cmd_rw_hold", mem_req_rw, p_rw);
      end
      if (p_dat_wait) check("wb_bits_hold", mem_req_data_bits, p_bits);
      mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      case (rstate)
        0: if (mem_req_valid) begin
          if (!cmd_pend) begin
            cmd_pend  = 1'b1;
            stall_cnt = (force_cmd_stall > 0) ? force_cmd_stall : int'($urandom_range(0, 2));
          end
          if (stall_cnt > 0) begin
            stall_cnt--;
          end else begin
            cmd_t c;
            mem_req_ready = 1'b1;
            cmd_pend = 1'b0;
            check("cmd_expected", cmd_q.size() != 0, 1'b1);
            if (cmd_q.size() != 0) begin
              c = cmd_q.pop_front();
              check("cmd_rw", mem_req_rw, c.rw);
              check("cmd_addr", mem_req_addr, c.addr);
            end
            r_addr = mem_req_addr; rbeat = 0; dstall_cnt = 0;
            rstate = mem_req_rw ? 1 : 2;
          end
        end
        1: if (mem_req_data_valid) begin
          if (dstall_cnt > 0) begin
            dstall_cnt--;
          end else if ($urandom_range(0, 3) != 0) begin
            mem_req_data_ready = 1'b1;
            check("wb_mask", mem_req_data_mask, 16'hFFFF);
            for (int j = 0; j < 4; j++) begin
              int unsigned wa;
              wa = (int'(r_addr) + rbeat) * 4 + j;
              check("wb_word", mem_req_data_bits[32*j +: 32], ref_rd(wa));
              bk_mem[wa] = mem_req_data_bits[32*j +: 32];
            end
            rbeat++;
            if (rbeat == 1) dstall_cnt = force_data_stall;
            if (rbeat == 4) rstate = 0;
          end
        end
        2: if ($urandom_range(0, 2) != 0) begin
          int unsigned ba;
          ba = int'(r_addr) + rbeat;
          mem_resp_valid = 1'b1;
          mem_resp_data  = {bk_rd(ba*4+3), bk_rd(ba*4+2), bk_rd(ba*4+1), bk_rd(ba*4)};
          rbeat++;
          if (rbeat == 4) begin
            last_fill_cyc = cyc;
            rstate = 0;
          end
        end
        default: rstate = 0;
      endcase
      p_cmd_wait = mem_req_valid && !mem_req_ready;
      p_addr     = mem_req_addr;
      p_rw       = mem_req_rw;
      p_dat_wait = mem_req_data_valid && !mem_req_data_ready;
      p_bits     = mem_req_data_bits;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (!reset && cpu_resp_valid) begin
      exp_t e;
      check("resp_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_data", cpu_resp_data, e.data);
        if (e.hit) check("hit_resp_latency", cyc - e.acc, 2);
        else       check("miss_resp_latency", cyc - last_fill_cyc, 2);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (!cpu_req_ready && w < TIMEOUT) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", cpu_req_ready, 1'b1);
  endtask

  task automatic cpu_access(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    bit          hit;
    logic [31:0] v;
    exp_t        e;
    wait_idle();
    hit = model_access(a, m != 4'b0000);
    if (m == 4'b0000) begin
      e.data = ref_rd(a); e.acc = cyc; e.hit = hit;
      exp_q.push_back(e);
    end else begin
      v = ref_rd(a);
      for (int b = 0; b < 4; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
      ref_mem[a] = v;
    end
    cpu_req_valid = 1'b1; cpu_req_addr = a; cpu_req_data = d; cpu_req_write = m;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    if (hit) begin
      @(negedge clk);
      check("busy_after_accept", cpu_req_ready, 1'b0);
      @(negedge clk);
      check("hit_ready_T2", cpu_req_ready, 1'b1);
    end
  endtask

  initial begin
    int w;
    reset = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_data = '0; cpu_req_write = '0;
    mem_req_ready = 1'b0; mem_req_data_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    model_reset();
    #1 reset = 1'b1;
    #12;
    check("rst_resp_valid", cpu_resp_valid, 1'b0);
    check("rst_resp_data", cpu_resp_data, 32'h0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_mem_rw", mem_req_rw, 1'b0);
    check("rst_mem_data_valid", mem_req_data_valid, 1'b0);
    check("rst_mem_addr", mem_req_addr, 28'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("ready_after_reset", cpu_req_ready, 1'b1);

    // Cold read of line 0x010, then a hit, a half-word store and a re-read
    preload(30'h010, 32'h44444444);
    preload(30'h011, 32'h33333333);
    preload(30'h012, 32'h22222222);
    preload(30'h013, 32'h11111111);
    cpu_access(30'h010, 32'h0, 4'b0000);
    cpu_access(30'h015, 32'h0, 4'b0000);
    cpu_access(30'h015, 32'hDEADBEEF, 4'b0011);
    cpu_access(30'h015, 32'h0, 4'b0000);

    // Three tags on index 5; dirty A is written back when C arrives
    cpu_access(30'h450, 32'hA0A1A2A3, 4'b1111);
    cpu_access(30'h85C, 32'h0, 4'b0000);
    force_data_stall = 3;
    cpu_access(30'hC53, 32'h0, 4'b0000);
    wait_idle();
    force_data_stall = 0;
    force_cmd_stall = 5;
    cpu_access(30'h1051, 32'h0, 4'b0000);
    wait_idle();
    force_cmd_stall = 0;
    cpu_access(30'hC50, 32'h0, 4'b0000);
    cpu_access(30'h854, 32'h0, 4'b0000);
    cpu_access(30'h450, 32'h0, 4'b0000);

    // Reset in the middle of a fill; the dirty line at 0x2000 is lost
    cpu_access(30'h2000, 32'h12345678, 4'b1111);
    cpu_access(30'h3040, 32'h0, 4'b0000);
    w = 0;
    @(negedge clk); #1;
    while (!(rstate == 2 && rbeat == 2) && w < TIMEOUT) begin
      @(negedge clk); #1;
      w++;
    end
    check("fill_beat2_reached", rbeat, 2);
    reset = 1'b1;
    #1;
    check("midrst_resp_valid", cpu_resp_valid, 1'b0);
    check("midrst_resp_data", cpu_resp_data, 32'h0);
    check("midrst_mem_valid", mem_req_valid, 1'b0);
    check("midrst_mem_rw", mem_req_rw, 1'b0);
    check("midrst_mem_data_valid", mem_req_data_valid, 1'b0);
    check("midrst_mem_addr", mem_req_addr, 28'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("ready_after_midrst", cpu_req_ready, 1'b1);
    cpu_access(30'h3040, 32'h0, 4'b0000);
    cpu_access(30'h2000, 32'h0, 4'b0000);

    // Random traffic over a small address pool to mix hits, misses and evictions
    for (int i = 0; i < 400; i++) begin
      int unsigned tg, ix, wd;
      logic [3:0]  m;
      tg = $urandom_range(0, 5);
      ix = $urandom_range(0, 3);
      wd = $urandom_range(0, 15);
      m  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      cpu_access(30'(tg * 1024 + ix * 16 + wd), $urandom, m);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("resp_queue_drained", exp_q.size(), 0);
    check("cmd_queue_drained", cmd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_assoc.md
# cache_assoc

Parametrised N-way set-associative, write-back, write-allocate data/instruction cache sitting between the CPU memory port and the 128-bit external memory interface. Next generation of the team's direct-mapped cache: set count and associativity are configurable, victim selection prefers invalid ways and otherwise uses a per-set round-robin pointer, and memory traffic uses one request plus a 4-beat data burst per line. With WAYS=1 it behaves as a direct-mapped write-back cache.

## Interface
- SETS, 64, number of sets; power of 2, ≥2
- WAYS, 2, associativity; power of 2, 1..8
- CPU_WIDTH, 32, CPU word width
- WORD_ADDR_BITS, 30, CPU word-address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- cpu_req_valid  in  1  request valid
- cpu_req_ready  out  1  high only in IDLE
- cpu_req_addr  in  WORD_ADDR_BITS  word address; [3:0] word-in-line, next log2(SETS) bits index, rest tag
- cpu_req_data  in  CPU_WIDTH  store data
- cpu_req_write  in  4  byte write mask; 0 = read
- cpu_resp_valid  out  1  read data valid, one-cycle pulse
- cpu_resp_data  out  CPU_WIDTH  read data
- mem_req_valid / mem_req_ready  out / in  1  command handshake
- mem_req_addr  out  WORD_ADDR_BITS-2  128-bit-beat address, always line-aligned (low 2 bits 0)
- mem_req_rw  out  1  1 = write
- mem_req_data_valid / mem_req_data_ready  out / in  1  write-data handshake
- mem_req_data_bits  out  128  write beat
- mem_req_data_mask  out  16  constant all ones
- mem_resp_valid  in  1  read beat valid
- mem_resp_data  in  128  read beat

## Operation
- Line = 16 words = 4 beats; word w lives in beat w[3:2], bits [32*w[1:0] +: 32].
- Per way per set: valid, dirty, tag in flops (async-cleared valid/dirty); data array not reset.
- States: IDLE, LOOKUP, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA.
- IDLE: on cpu_req_valid, latch addr/data/mask → LOOKUP.
- LOOKUP hit (tag match, valid): read → cpu_resp_valid=1 next cycle with selected word; write → byte-masked update, set dirty, no response. → IDLE.
- LOOKUP miss: victim = lowest-index invalid way, else rr_ptr[set]. Victim valid & dirty → WB_REQ, else → FILL_REQ.
- WB_REQ: mem_req_valid=1, rw=1, addr={victim tag, index, 2'b00}; on mem_req_ready → WB_DATA.
- WB_DATA: mem_req_data_valid=1, bits=victim beat k (k=0..3); k advances on mem_req_data_ready; after beat 3 → FILL_REQ.
- FILL_REQ: mem_req_valid=1, rw=0, addr={req tag, index, 2'b00}; on ready → FILL_DATA.
- FILL_DATA: each mem_resp_valid writes beat k; after beat 3: tag written, valid=1, dirty=0, rr_ptr[set] += 1 (mod WAYS) only if victim was chosen by pointer; → LOOKUP (replay, guaranteed hit, store merges then).
- mem_resp_valid outside FILL_DATA ignored; mem_req_ready outside *_REQ ignored.
- Outputs mem_req_*, cpu_req_ready are Moore decodes of state; cpu_resp_valid, cpu_resp_data registered.

## Timing
- Reset (async): state IDLE, beat counter 0, all valid/dirty 0, rr_ptr 0; cpu_resp_valid 0, cpu_resp_data 0, mem_req_valid 0, mem_req_rw 0, mem_req_data_valid 0, mem_req_addr 0; cpu_req_ready 1 after release.
- Read hit: accepted edge T; cpu_resp_valid high cycle T+2 (one cycle), cpu_req_ready high same cycle.
- Write hit: ready again at T+2.
- Clean miss: FILL_REQ entered T+2; response 2 cycles after final fill beat (LOOKUP, then resp).
- mem_req_valid, addr, rw held stable while ready low; data bits held while data_ready low.
- Reset mid-transaction: transaction abandoned, dirty data lost, outputs to reset values immediately.

## Test plan
- Cold read word 0x010 (SETS=64, WAYS=2): one read cmd addr 0x004, 4 beats (beat0=0x…_1111_2222_3333_4444) → cpu_resp_data=0x44444444 two cycles after beat 3; no write traffic.
- Read word 0x015 after above: cpu_resp_valid at T+2, no mem_req_valid.
- Write 0xDEADBEEF mask 4'b0011 to 0x015, then read 0x015 → upper halfword original, lower 0xBEEF.
- Tags A,B,C same index, A dirty: C access → write cmd at A's line addr with 4 beats holding A data, then fill of C into way 0; next miss D evicts way 1.
- Hold mem_req_ready low 5 cycles in FILL_REQ: valid/addr/rw stable; hold data_ready low mid-WB_DATA: beat unchanged.
- Assert reset during FILL_DATA beat 2: all outputs 0 same cycle; after release re-read same line → fresh miss.
